// File: rtl/instr_encoder.sv
// instr_encoder: streaming MIPS instruction encoder / instruction-memory loader.
// Turns symbolic instructions (op_id + operand fields) into 32-bit machine
// words. The words are written one per cycle into sequential instruction-memory
// addresses. The li pseudo-op expands into a single ori, or into a lui/ori pair.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   clear           synchronous: address counter -> 0, error flags cleared,
//                   any pending li low word dropped
//   in_valid/ready  item handshake; an item is taken when both are high
//   op_id           operation ID (0..31 legal, 32..63 illegal)
//   rs,rt,rd,shamt  register / shift fields
//   imm             immediate (width used depends on the operation)
//   mem_we          one-cycle write strobe per emitted word
//   mem_addr        word address of mem_wdata
//   mem_wdata       encoded instruction (held when mem_we is low)
//   full            last memory word has been written
//   err_illegal     sticky: an illegal op_id was consumed
//   err_overflow    sticky: a two-word li arrived with only one free slot
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op_id,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              full,
    output logic              err_illegal,
    output logic              err_overflow
);

    typedef enum logic {IDLE = 1'b0, LO = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    // Single-word encoding for op_id 0..30 (li is expanded separately).
    function automatic logic [31:0] encode(
        input logic [5:0]  op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_sh,
        input logic [31:0] f_imm
    );
        logic [31:0] w;
        case (op)
            6'd0:  w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100000};
            6'd1:  w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100010};
            6'd2:  w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100001};
            6'd3:  w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100011};
            6'd4:  w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100100};
            6'd5:  w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100101};
            6'd6:  w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100110};
            // Shifts take their source from rt; rs is forced to zero.
            6'd7:  w = {6'b000000, 5'd0, f_rt, f_rd, f_sh, 6'b000000};
            6'd8:  w = {6'b000000, 5'd0, f_rt, f_rd, f_sh, 6'b000010};
            6'd9:  w = {6'b000000, 5'd0, f_rt, f_rd, f_sh, 6'b000011};
            6'd10: w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b101010};
            6'd11: w = {6'b000000, f_rs, 15'd0, 6'b001000};
            6'd12: w = {6'b001000, f_rs, f_rt, f_imm[15:0]};
            6'd13: w = {6'b001001, f_rs, f_rt, f_imm[15:0]};
            6'd14: w = {6'b001100, f_rs, f_rt, f_imm[15:0]};
            6'd15: w = {6'b001101, f_rs, f_rt, f_imm[15:0]};
            6'd16: w = {6'b001110, f_rs, f_rt, f_imm[15:0]};
            6'd17: w = {6'b001111, 5'd0, f_rt, f_imm[15:0]};
            6'd18: w = {6'b100011, f_rs, f_rt, f_imm[15:0]};
            6'd19: w = {6'b101011, f_rs, f_rt, f_imm[15:0]};
            6'd20: w = {6'b000100, f_rs, f_rt, f_imm[15:0]};
            6'd21: w = {6'b000101, f_rs, f_rt, f_imm[15:0]};
            6'd22: w = {6'b000010, f_imm[25:0]};
            6'd23: w = {6'b000011, f_imm[25:0]};
            // Custom 011111 group: 10-bit signed offset sits where rd/shamt would.
            6'd24: w = {6'b011111, f_rs, f_rt, f_imm[9:0], 6'b010001};
            6'd25: w = {6'b011111, f_rs, f_rt, f_imm[9:0], 6'b010010};
            6'd26: w = {6'b011111, f_rs, f_rt, f_imm[9:0], 6'b010011};
            6'd27: w = {6'b011111, f_rs, f_rt, f_imm[9:0], 6'b010100};
            6'd28: w = {6'b011111, f_rs, f_rt, f_imm[9:0], 6'b010101};
            6'd29: w = {6'b011111, f_rs, f_rt, f_imm[9:0], 6'b010110};
            6'd30: w = {6'b011111, f_rs, f_rt, f_rd, 5'd0, 6'b011000};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]         lo_word_q, lo_word_d;
    logic                mem_we_q, mem_we_d;
    logic                full_q, full_d;
    logic                err_illegal_q, err_illegal_d;
    logic                err_overflow_q, err_overflow_d;

    logic                accept;
    logic                is_li;
    logic                li_two;
    logic                last_slot;
    logic                wr_en;
    logic [31:0]         wr_word;

    assign in_ready  = !full_q && (state_q == IDLE) && !clear;
    assign accept    = in_valid && in_ready;
    assign is_li     = (op_id == 6'd31);
    assign li_two    = is_li && (imm[31:16] != 16'd0);
    assign last_slot = (ptr_q == LAST_ADDR);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a two-word li that fits moves to LO for exactly one cycle.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept && li_two && !last_slot) state_d = LO;
                LO:      state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs / datapath next values
    always_comb begin
        ptr_d          = ptr_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        lo_word_d      = lo_word_q;
        mem_we_d       = 1'b0;
        full_d         = full_q;
        err_illegal_d  = err_illegal_q;
        err_overflow_d = err_overflow_q;
        wr_en          = 1'b0;
        wr_word        = 32'd0;

        if (clear) begin
            ptr_d          = '0;
            mem_addr_d     = '0;
            full_d         = 1'b0;
            err_illegal_d  = 1'b0;
            err_overflow_d = 1'b0;
        end else if (state_q == LO) begin
            wr_en   = 1'b1;
            wr_word = lo_word_q;
        end else if (accept) begin
            if (op_id[5]) begin
                err_illegal_d = 1'b1;
            end else if (li_two) begin
                // A lui/ori pair must never be split across the end of memory.
                if (last_slot) begin
                    err_overflow_d = 1'b1;
                end else begin
                    wr_en     = 1'b1;
                    wr_word   = {6'b001111, 5'd0, rt, imm[31:16]};
                    lo_word_d = {6'b001101, rt, rt, imm[15:0]};
                end
            end else if (is_li) begin
                wr_en   = 1'b1;
                wr_word = {6'b001101, 5'd0, rt, imm[15:0]};
            end else begin
                wr_en   = 1'b1;
                wr_word = encode(op_id, rs, rt, rd, shamt, imm);
            end
        end

        if (wr_en) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = wr_word;
            mem_addr_d  = ptr_q;
            // The counter parks on the last address; full blocks further input.
            if (last_slot) begin
                full_d = 1'b1;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q          <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 32'd0;
            lo_word_q      <= 32'd0;
            mem_we_q       <= 1'b0;
            full_q         <= 1'b0;
            err_illegal_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            lo_word_q      <= lo_word_d;
            mem_we_q       <= mem_we_d;
            full_q         <= full_d;
            err_illegal_q  <= err_illegal_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign full         = full_q;
    assign err_illegal  = err_illegal_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: a default-size instance (ADDR_W=10) and a
// 4-word instance (ADDR_W=2) for the end-of-memory behaviour.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear, in_valid, clear_s, in_valid_s;
    logic        in_ready, in_ready_s;
    logic [5:0]  op_id;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm;
    logic        mem_we, mem_we_s;
    logic [9:0]  mem_addr;
    logic [1:0]  mem_addr_s;
    logic [31:0] mem_wdata, mem_wdata_s;
    logic        full, full_s, err_illegal, err_illegal_s, err_overflow, err_overflow_s;

    int n_vec = 0;
    int n_err = 0;

    int          obs_addr[$];
    logic [31:0] obs_data[$];

    instr_encoder #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .op_id(op_id), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .full(full),
        .err_illegal(err_illegal), .err_overflow(err_overflow)
    );

    instr_encoder #(.ADDR_W(2)) dut_s (
        .clk(clk), .rst(rst), .clear(clear_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .op_id(op_id), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
        .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .full(full_s),
        .err_illegal(err_illegal_s), .err_overflow(err_overflow_s)
    );

    always #5 clk = ~clk;

    // Write log of the large instance
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs_addr.push_back(int'(mem_addr));
            obs_data.push_back(mem_wdata);
        end
    end

    // ---------------- reference model ----------------
    localparam int R_FUNCT [12] = '{32, 34, 33, 35, 36, 37, 38, 0, 2, 3, 42, 8};
    localparam int I_OPC   [10] = '{8, 9, 12, 13, 14, 15, 35, 43, 4, 5};
    localparam int B_FUNCT [6]  = '{17, 18, 19, 20, 21, 22};

    function automatic logic [31:0] pack(input int opc, input int a, input int b,
                                         input int c, input int d, input int e);
        logic [31:0] v;
        v = (32'(opc) << 26) | (32'(a) << 21) | (32'(b) << 16) |
            (32'(c) << 11) | (32'(d) << 6) | 32'(e);
        return v;
    endfunction

    // Returns number of words emitted (0, 1 or 2) for one item.
    function automatic int model_words(input int op, input int f_rs, input int f_rt,
                                       input int f_rd, input int f_sh, input logic [31:0] f_imm,
                                       output logic [31:0] w0, output logic [31:0] w1);
        int s, t, d, h;
        s = f_rs; t = f_rt; d = f_rd; h = f_sh;
        w0 = 32'd0;
        w1 = 32'd0;
        if (op > 31) return 0;
        if (op <= 11) begin
            if (op >= 7 && op <= 9) s = 0;
            else if (op == 11) begin t = 0; d = 0; h = 0; end
            else h = 0;
            w0 = pack(0, s, t, d, h, R_FUNCT[op]);
            return 1;
        end
        if (op <= 21) begin
            if (op == 17) s = 0;
            w0 = pack(I_OPC[op-12], s, t, 0, 0, 0) | (f_imm & 32'h0000_FFFF);
            return 1;
        end
        if (op <= 23) begin
            w0 = (32'(op - 20) << 26) | (f_imm & 32'h03FF_FFFF);
            return 1;
        end
        if (op <= 29) begin
            w0 = pack(31, s, t, 0, 0, B_FUNCT[op-24]) | ((f_imm & 32'h0000_03FF) << 6);
            return 1;
        end
        if (op == 30) begin
            w0 = pack(31, s, t, d, 0, 24);
            return 1;
        end
        if ((f_imm >> 16) != 32'd0) begin
            w0 = pack(15, 0, t, 0, 0, 0) | (f_imm >> 16);
            w1 = pack(13, t, t, 0, 0, 0) | (f_imm & 32'h0000_FFFF);
            return 2;
        end
        w0 = pack(13, 0, t, 0, 0, 0) | (f_imm & 32'h0000_FFFF);
        return 1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic set_item(input int op, input int a, input int b, input int c,
                            input int d, input logic [31:0] v);
        op_id = 6'(op); rs = 5'(a); rt = 5'(b); rd = 5'(c); shamt = 5'(d); imm = v;
    endtask

    task automatic clear_big;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({mem_we, mem_addr, mem_wdata, full, err_illegal, err_overflow} !== 46'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got we=%b addr=%0d wdata=%h full=%b ill=%b ovf=%b, want all 0",
                     mem_we, mem_addr, mem_wdata, full, err_illegal, err_overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, in_ready_s, mem_we_s, full_s} !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%b rdy_s=%b we_s=%b full_s=%b, want 1 1 0 0",
                     in_ready, in_ready_s, mem_we_s, full_s);
        end
    endtask

    task automatic test_add;
        clear_big();
        set_item(0, 1, 2, 3, 7, 32'd0);
        in_valid = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL add_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd0, 32'h0022_1820}) begin
            n_err++;
            $display("FAIL add_write: got we=%b addr=%0d wdata=%h want 1 0 00221820", mem_we, mem_addr, mem_wdata);
        end
        tick();
        n_vec++;
        if ({mem_we, mem_wdata} !== {1'b0, 32'h0022_1820}) begin
            n_err++;
            $display("FAIL add_pulse: got we=%b wdata=%h want 0 00221820 held", mem_we, mem_wdata);
        end
    endtask

    task automatic test_li_two;
        clear_big();
        set_item(31, 0, 8, 0, 0, 32'h1234_5678);
        in_valid = 1'b1;
        tick();
        set_item(0, 1, 2, 3, 7, 32'd0);
        #1;
        n_vec++;
        if ({mem_we, mem_addr, mem_wdata, in_ready} !== {1'b1, 10'd0, 32'h3C08_1234, 1'b0}) begin
            n_err++;
            $display("FAIL li_lui: got we=%b addr=%0d wdata=%h rdy=%b want 1 0 3c081234 0",
                     mem_we, mem_addr, mem_wdata, in_ready);
        end
        tick();
        n_vec++;
        if ({mem_we, mem_addr, mem_wdata, in_ready} !== {1'b1, 10'd1, 32'h3508_5678, 1'b1}) begin
            n_err++;
            $display("FAIL li_ori: got we=%b addr=%0d wdata=%h rdy=%b want 1 1 35085678 1",
                     mem_we, mem_addr, mem_wdata, in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd2, 32'h0022_1820}) begin
            n_err++;
            $display("FAIL li_b2b_add: got we=%b addr=%0d wdata=%h want 1 2 00221820", mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_formats;
        clear_big();
        set_item(31, 0, 8, 0, 0, 32'h0000_BEEF);
        in_valid = 1'b1;
        tick();
        set_item(22, 9, 9, 9, 9, 32'h0000_0100);
        n_vec++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd0, 32'h3408_BEEF}) begin
            n_err++;
            $display("FAIL li_single: got we=%b addr=%0d wdata=%h want 1 0 3408beef", mem_we, mem_addr, mem_wdata);
        end
        tick();
        set_item(24, 1, 2, 0, 0, 32'd5);
        n_vec++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd1, 32'h0800_0100}) begin
            n_err++;
            $display("FAIL j_word: got we=%b addr=%0d wdata=%h want 1 1 08000100", mem_we, mem_addr, mem_wdata);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd2, 32'h7C22_0151}) begin
            n_err++;
            $display("FAIL bgt_word: got we=%b addr=%0d wdata=%h want 1 2 7c220151", mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_illegal;
        clear_big();
        set_item(40, 1, 2, 3, 4, 32'hFFFF_FFFF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({mem_we, err_illegal} !== 2'b01) begin
            n_err++; $display("FAIL illegal_flag: got we=%b ill=%b want 0 1", mem_we, err_illegal);
        end
        set_item(0, 1, 2, 3, 7, 32'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({mem_we, mem_addr, mem_wdata, err_illegal} !== {1'b1, 10'd0, 32'h0022_1820, 1'b1}) begin
            n_err++;
            $display("FAIL illegal_next: got we=%b addr=%0d wdata=%h ill=%b want 1 0 00221820 1",
                     mem_we, mem_addr, mem_wdata, err_illegal);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_vec++;
        if ({err_illegal, mem_addr} !== {1'b0, 10'd0}) begin
            n_err++; $display("FAIL illegal_clear: got ill=%b addr=%0d want 0 0", err_illegal, mem_addr);
        end
    endtask

    task automatic test_small_overflow;
        clear_s = 1'b1;
        tick();
        clear_s = 1'b0;
        set_item(0, 1, 2, 3, 7, 32'd0);
        in_valid_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({mem_we_s, mem_addr_s, mem_wdata_s} !== {1'b1, 2'(i), 32'h0022_1820}) begin
                n_err++;
                $display("FAIL small_add%0d: got we=%b addr=%0d wdata=%h want 1 %0d 00221820",
                         i, mem_we_s, mem_addr_s, mem_wdata_s, i);
            end
        end
        set_item(31, 0, 8, 0, 0, 32'h1234_5678);
        tick();
        set_item(0, 1, 2, 3, 7, 32'd0);
        #1;
        n_vec++;
        if ({mem_we_s, err_overflow_s, full_s, in_ready_s} !== 4'b0101) begin
            n_err++;
            $display("FAIL small_overflow: got we=%b ovf=%b full=%b rdy=%b want 0 1 0 1",
                     mem_we_s, err_overflow_s, full_s, in_ready_s);
        end
        tick();
        n_vec++;
        if ({mem_we_s, mem_addr_s, full_s, in_ready_s} !== {1'b1, 2'd3, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL small_full: got we=%b addr=%0d full=%b rdy=%b want 1 3 1 0",
                     mem_we_s, mem_addr_s, full_s, in_ready_s);
        end
        tick();
        tick();
        n_vec++;
        if ({mem_we_s, full_s} !== 2'b01) begin
            n_err++; $display("FAIL small_hold: got we=%b full=%b want 0 1", mem_we_s, full_s);
        end
        in_valid_s = 1'b0;
        clear_s = 1'b1;
        tick();
        clear_s = 1'b0;
        #1;
        n_vec++;
        if ({mem_addr_s, full_s, err_overflow_s, in_ready_s} !== {2'd0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL small_clear: got addr=%0d full=%b ovf=%b rdy=%b want 0 0 0 1",
                     mem_addr_s, full_s, err_overflow_s, in_ready_s);
        end
    endtask

    task automatic test_random;
        int          exp_addr[$];
        logic [31:0] exp_data[$];
        int          exp_ptr;
        logic        exp_ill;
        int          nw, guard, op, a, b, c, d, lim;
        logic [31:0] v, w0, w1;
        exp_ptr = 0;
        exp_ill = 1'b0;
        clear_big();
        obs_addr.delete();
        obs_data.delete();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(32, 63)) : int'($urandom_range(0, 31));
            a = int'($urandom_range(0, 31)); b = int'($urandom_range(0, 31));
            c = int'($urandom_range(0, 31)); d = int'($urandom_range(0, 31));
            v = $urandom;
            if ($urandom_range(0, 1) == 1) v = v & 32'h0000_FFFF;
            set_item(op, a, b, c, d, v);
            in_valid = 1'b1;
            #1;
            guard = 0;
            while (in_ready !== 1'b1 && guard < 20) begin
                tick();
                guard++;
            end
            if (in_ready !== 1'b1) begin
                n_vec++; n_err++;
                $display("FAIL random_ready_timeout: got rdy=%b want 1 within 20 cycles", in_ready);
                break;
            end
            // Item is taken on the coming edge.
            nw = model_words(op, a, b, c, d, v, w0, w1);
            if (op > 31) exp_ill = 1'b1;
            if (nw >= 1) begin exp_addr.push_back(exp_ptr); exp_data.push_back(w0); exp_ptr++; end
            if (nw == 2) begin exp_addr.push_back(exp_ptr); exp_data.push_back(w1); exp_ptr++; end
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        n_vec++;
        if (obs_addr.size() != exp_addr.size()) begin
            n_err++;
            $display("FAIL random_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size());
        end
        lim = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < lim; i++) begin
            n_vec++;
            if (obs_addr[i] != exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                n_err++;
                $display("FAIL random_word%0d: got addr=%0d data=%h want addr=%0d data=%h",
                         i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_vec++;
        if ({err_illegal, err_overflow} !== {exp_ill, 1'b0}) begin
            n_err++;
            $display("FAIL random_flags: got ill=%b ovf=%b want %b 0", err_illegal, err_overflow, exp_ill);
        end
    endtask

    task automatic test_rst_mid_li;
        clear_big();
        set_item(40, 0, 0, 0, 0, 32'd0);
        in_valid = 1'b1;
        tick();
        set_item(31, 0, 8, 0, 0, 32'hCAFE_0001);
        tick();
        in_valid = 1'b0;
        n_vec++;
        if ({mem_we, mem_wdata, in_ready, err_illegal} !== {1'b1, 32'h3C08_CAFE, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL rstli_lui: got we=%b wdata=%h rdy=%b ill=%b want 1 3c08cafe 0 1",
                     mem_we, mem_wdata, in_ready, err_illegal);
        end
        #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({mem_we, mem_addr, mem_wdata, full, err_illegal, err_overflow, in_ready} !== {46'd0, 1'b1}) begin
            n_err++;
            $display("FAIL rstli_async: got we=%b addr=%0d wdata=%h full=%b ill=%b ovf=%b rdy=%b want 0 0 0 0 0 0 1",
                     mem_we, mem_addr, mem_wdata, full, err_illegal, err_overflow, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({mem_we, mem_addr, in_ready} !== {1'b0, 10'd0, 1'b1}) begin
                n_err++;
                $display("FAIL rstli_after%0d: got we=%b addr=%0d rdy=%b want 0 0 1", i, mem_we, mem_addr, in_ready);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0; in_valid = 1'b0; clear_s = 1'b0; in_valid_s = 1'b0;
        set_item(0, 0, 0, 0, 0, 32'd0);
        test_reset();
        test_add();
        test_li_two();
        test_formats();
        test_illegal();
        test_small_overflow();
        test_random();
        test_rst_mid_li();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming MIPS instruction encoder and instruction-memory loader: the inverse of the control decoder.
- Accepts symbolic instructions (operation ID plus operand fields) over a valid/ready handshake and emits the 32-bit machine word.
- Uses the same opcode/funct map the decoder consumes, including the custom 011111 branch/seq group.
- Writes words sequentially into instruction memory; expands the `li` pseudo-op into one or two words. Used by boot/test loaders.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; depth = 2^ADDR_W words.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous; returns address counter to 0 and clears err flags.
- in_valid  in  1  instruction item valid.
- in_ready  out  1  encoder can accept an item this cycle.
- op_id  in  6  operation ID (see Behaviour).
- rs, rt, rd, shamt  in  5 each  register/shift fields.
- imm  in  32  immediate. Low 16 bits for I-type, low 26 for J-type, low 10 (signed offset) for custom branches, all 32 for li.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  word address of mem_wdata.
- mem_wdata  out  32  encoded instruction.
- full  out  1  last memory word written; no further writes.
- err_illegal  out  1  sticky; an op_id > 31 was received.
- err_overflow  out  1  sticky; an li needed 2 words but only 1 slot remained.

Behaviour:
- op_id map:
  - 0 add, 1 sub, 2 addu, 3 subu, 4 and, 5 or, 6 xor, 7 sll, 8 srl, 9 sra, 10 slt, 11 jr
  - 12 addi, 13 addiu, 14 andi, 15 ori, 16 xori, 17 lui, 18 lw, 19 sw, 20 beq, 21 bne
  - 22 j, 23 jal
  - 24 bgt, 25 bgte, 26 ble, 27 bleq, 28 bleu, 29 bgtu, 30 seq
  - 31 li
  - 32–63 illegal
- Formats:
  - R-type: {000000,rs,rt,rd,shamt,funct}. Funct: add 100000, sub 100010, addu 100001, subu 100011, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, slt 101010, jr 001000.
  - R-type field forcing: shifts force rs=0. jr forces rt=rd=shamt=0. Other R ops force shamt=0.
  - I-type: {opcode,rs,rt,imm[15:0]}. Opcodes: addi 001000, addiu 001001, andi 001100, ori 001101, xori 001110, lui 001111 (rs forced 0), lw 100011, sw 101011, beq 000100, bne 000101.
  - J-type: {000010 j / 000011 jal, imm[25:0]}.
  - Custom branches: {011111,rs,rt,imm[9:0],funct}. Funct: bgt 010001, bgte 010010, ble 010011, bleq 010100, bleu 010101, bgtu 010110.
  - seq: {011111,rs,rt,rd,00000,011000}.
- li:
  - If imm[31:16] != 0: emit two words, lui rt,imm[31:16] then ori rt,rt,imm[15:0].
  - If imm[31:16] == 0: emit one word, ori rt,$0,imm[15:0].
- States:
  - IDLE: no second word pending.
  - LO: li low word pending.
  - Transitions: IDLE→LO on acceptance of a two-word li; LO→IDLE unconditionally after one cycle.
- Handshake: accept when in_valid && in_ready. in_ready = !full && state==IDLE && !clear.
- Latency:
  - Accept in cycle N → registered mem_we=1 with mem_addr/mem_wdata valid in cycle N+1.
  - Two-word li: writes in N+1 (lui) and N+2 (ori); in_ready low during the LO cycle.
  - Throughput: 1 word per cycle.
- Address counter:
  - mem_addr holds the address of the current write; it increments after every write.
  - A write to address 2^ADDR_W−1 sets full. The counter does not wrap; full holds until clear or rst.
- Two-word li with exactly one free slot: no write, err_overflow set, item consumed.
- Illegal op_id: item consumed, no write, err_illegal set.
- mem_we is a 1-cycle pulse per word. mem_wdata is don't-care when mem_we=0 but is held stable.
- clear while state LO: pending low word is dropped, state→IDLE, counter→0.
- Reset values (rst asserted, any time including mid-li):
  - state IDLE
  - mem_we 0, mem_addr 0, mem_wdata 0
  - full 0, err_illegal 0, err_overflow 0
  - in_ready 1 after release

Test Plan:
- add, rs=1 rt=2 rd=3 shamt=7 → next cycle mem_we=1, addr 0, wdata 0x00221820 (shamt forced 0).
- li rt=8 imm=0x12345678 → addr 0 0x3C081234, addr 1 0x35085678 on consecutive cycles; in_ready low for 1 cycle; a back-to-back add lands at addr 2.
- li rt=8 imm=0x0000BEEF → single write 0x3408BEEF; j imm=0x100 → 0x08000100; bgt rs=1 rt=2 imm=5 → 0x7C220151.
- op_id=40 → no mem_we, err_illegal=1, sticky until clear; the next valid item writes at the unchanged address.
- ADDR_W=2:
  - Three adds, then two-word li → err_overflow=1, no write.
  - Fourth add → write at addr 3, full=1, in_ready=0.
  - clear → addr 0, flags 0.
- Two-word li accepted, rst asserted during the LO cycle → mem_we=0 immediately, outputs at reset values, no ori word written after release.
